// File: rtl/pet2001_prg_loader_if.sv
// Download byte stream in, RAM DMA write port out; the loader takes the master modport.
// Latency: none (wires only).  Backpressure: dl_ready qualifies dl_valid.
interface pet2001_prg_loader_if;
  logic        dl_active;
  logic        dl_valid;
  logic [7:0]  dl_data;
  logic        dl_ready;
  logic [15:0] dma_addr;
  logic [7:0]  dma_din;
  logic        dma_we;

  modport master (
    input  dl_active, dl_valid, dl_data,
    output dl_ready, dma_addr, dma_din, dma_we
  );

  modport slave (
    output dl_active, dl_valid, dl_data,
    input  dl_ready, dma_addr, dma_din, dma_we
  );
endinterface

// File: rtl/pet2001_prg_loader.sv
// PET PRG loader: 2-byte load address, body DMA'd to RAM, optional VARTAB/ARYTAB/STREND patch (PRG_PATCH_PTRS_EN).
// Latency: accepted byte -> dma_we one clk later; one byte per clk sustained.
// Backpressure: dl_ready = dl_active while in ADDR_LO/ADDR_HI/DATA/DRAIN, else 0.
module pet2001_prg_loader #(
  parameter logic [7:0] PTR_BASE = 8'h2A
) (
  input  logic                        clk,
  input  logic                        reset_n,
  pet2001_prg_loader_if.master        dl,
  output logic                        busy,
  output logic                        done,
  output logic                        err
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR_LO, S_ADDR_HI, S_DATA, S_DRAIN, S_PATCH, S_DONE
  } state_t;

  state_t      state, state_nxt;
  logic        active_q;
  logic [15:0] load_addr, load_addr_nxt;
  logic [15:0] cur_addr, cur_addr_nxt;
  logic [15:0] dma_addr_nxt;
  logic [7:0]  dma_din_nxt;
  logic        dma_we_nxt;
  logic        err_nxt;
  logic        rise;
  logic        accept;
`ifdef PRG_PATCH_PTRS_EN
  logic [2:0]  patch_cnt, patch_cnt_nxt;
`endif

  assign rise     = dl.dl_active & ~active_q;
  assign dl.dl_ready = dl.dl_active &
                       ((state == S_ADDR_LO) || (state == S_ADDR_HI) ||
                        (state == S_DATA)    || (state == S_DRAIN));
  assign accept   = dl.dl_active & dl.dl_valid & dl.dl_ready;
  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);

  always_comb begin
    state_nxt     = state;
    load_addr_nxt = load_addr;
    cur_addr_nxt  = cur_addr;
    dma_addr_nxt  = dl.dma_addr;
    dma_din_nxt   = dl.dma_din;
    dma_we_nxt    = 1'b0;
    err_nxt       = err;
`ifdef PRG_PATCH_PTRS_EN
    patch_cnt_nxt = patch_cnt;
`endif
    if (rise) begin
      state_nxt = S_ADDR_LO;
      err_nxt   = 1'b0;
    end else begin
      case (state)
        S_ADDR_LO: begin
          if (!dl.dl_active) begin
            err_nxt   = 1'b1;
            state_nxt = S_IDLE;
          end else if (accept) begin
            load_addr_nxt[7:0] = dl.dl_data;
            state_nxt          = S_ADDR_HI;
          end
        end
        S_ADDR_HI: begin
          if (!dl.dl_active) begin
            err_nxt   = 1'b1;
            state_nxt = S_IDLE;
          end else if (accept) begin
            load_addr_nxt[15:8] = dl.dl_data;
            cur_addr_nxt        = {dl.dl_data, load_addr[7:0]};
            // Load address above RAM: nothing in this file can be written.
            if (dl.dl_data[7]) begin
              err_nxt   = 1'b1;
              state_nxt = S_DRAIN;
            end else begin
              state_nxt = S_DATA;
            end
          end
        end
        S_DATA: begin
          if (!dl.dl_active) begin
`ifdef PRG_PATCH_PTRS_EN
            // First pointer write issues here so PATCH shows six back-to-back strobes.
            dma_we_nxt    = 1'b1;
            dma_addr_nxt  = {8'h00, PTR_BASE};
            dma_din_nxt   = cur_addr[7:0];
            patch_cnt_nxt = 3'd1;
            state_nxt     = S_PATCH;
`else
            state_nxt     = S_DONE;
`endif
          end else if (accept) begin
            if (cur_addr[15]) begin
              err_nxt   = 1'b1;
              state_nxt = S_DRAIN;
            end else begin
              dma_we_nxt   = 1'b1;
              dma_addr_nxt = cur_addr;
              dma_din_nxt  = dl.dl_data;
              cur_addr_nxt = cur_addr + 16'd1;
            end
          end
        end
        S_DRAIN: begin
          if (!dl.dl_active) state_nxt = S_IDLE;
        end
        S_PATCH: begin
`ifdef PRG_PATCH_PTRS_EN
          if (patch_cnt == 3'd6) begin
            state_nxt = S_DONE;
          end else begin
            dma_we_nxt    = 1'b1;
            dma_addr_nxt  = {8'h00, PTR_BASE + {5'd0, patch_cnt}};
            dma_din_nxt   = patch_cnt[0] ? cur_addr[15:8] : cur_addr[7:0];
            patch_cnt_nxt = patch_cnt + 3'd1;
          end
`else
          state_nxt = S_DONE;
`endif
        end
        S_DONE:  state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      active_q    <= 1'b0;
      load_addr   <= 16'h0000;
      cur_addr    <= 16'h0000;
      dl.dma_addr <= 16'h0000;
      dl.dma_din  <= 8'h00;
      dl.dma_we   <= 1'b0;
      err         <= 1'b0;
`ifdef PRG_PATCH_PTRS_EN
      patch_cnt   <= 3'd0;
`endif
    end else begin
      state       <= state_nxt;
      active_q    <= dl.dl_active;
      load_addr   <= load_addr_nxt;
      cur_addr    <= cur_addr_nxt;
      dl.dma_addr <= dma_addr_nxt;
      dl.dma_din  <= dma_din_nxt;
      dl.dma_we   <= dma_we_nxt;
      err         <= err_nxt;
`ifdef PRG_PATCH_PTRS_EN
      patch_cnt   <= patch_cnt_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_pet2001_prg_loader.sv
// Bench for pet2001_prg_loader: directed PRG streams plus random files against a queue-based model.
module tb_pet2001_prg_loader;
  localparam logic [7:0] PB = 8'h2A;
`ifdef PRG_PATCH_PTRS_EN
  localparam bit PATCH_EN = 1'b1;
`else
  localparam bit PATCH_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  logic busy, done, err;

  pet2001_prg_loader_if dl ();

  pet2001_prg_loader #(.PTR_BASE(PB)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .dl      (dl),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  int unsigned cyc = 0;
  int unsigned drop_cyc = 0;
  int unsigned done_cyc = 0;
  int          done_cnt = 0;
  logic [23:0] obs_wr[$];
  int unsigned obs_cyc[$];
  logic [23:0] exp_wr[$];
  logic [7:0]  tx_q[$];
  bit          exp_err;
  bit          exp_done;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (dl.dma_we === 1'b1) begin
      obs_wr.push_back({dl.dma_addr, dl.dma_din});
      obs_cyc.push_back(cyc);
    end
    if (done === 1'b1) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: a PRG image is <lo><hi><body>; RAM stops at 0x7FFF.
  task automatic model();
    int a;
    int start;
    exp_wr.delete();
    exp_err = 1'b0;
    if (tx_q.size() < 2) begin
      exp_err = 1'b1;
    end else begin
      start = int'(tx_q[0]) + 256 * int'(tx_q[1]);
      a = start;
      if (start >= 32768) exp_err = 1'b1;
      for (int i = 2; i < tx_q.size() && !exp_err; i++) begin
        if (a >= 32768) exp_err = 1'b1;
        else begin
          exp_wr.push_back({a[15:0], tx_q[i]});
          a = a + 1;
        end
      end
      if (!exp_err && PATCH_EN) begin
        for (int k = 0; k < 6; k++)
          exp_wr.push_back({8'h00, PB + 8'(k), (k % 2 == 1) ? a[15:8] : a[7:0]});
      end
    end
    exp_done = !exp_err;
  endtask

  task automatic send_file(input int vld_pct);
    int idx;
    int guard;
    obs_wr.delete();
    obs_cyc.delete();
    done_cnt = 0;
    @(negedge clk);
    dl.dl_active = 1'b1;
    dl.dl_valid  = 1'b0;
    idx = 0;
    guard = 0;
    while (idx < tx_q.size() && guard < 3000) begin
      @(negedge clk);
      guard++;
      dl.dl_valid = ($urandom_range(99) < vld_pct);
      dl.dl_data  = dl.dl_valid ? tx_q[idx] : 8'($urandom);
      #1;
      if (dl.dl_valid && dl.dl_ready) idx++;
    end
    if (guard >= 3000) chk("send_timeout", 32'(idx), 32'(tx_q.size()));
    @(negedge clk);
    dl.dl_active = 1'b0;
    dl.dl_valid  = 1'b1;
    dl.dl_data   = 8'hEE;
    #1;
    drop_cyc = cyc;
    repeat (12) @(negedge clk);
    dl.dl_valid = 1'b0;
  endtask

  task automatic check_file(input string tag);
    int n;
    model();
    chk({tag, "_nwr"}, 32'(obs_wr.size()), 32'(exp_wr.size()));
    n = (obs_wr.size() < exp_wr.size()) ? obs_wr.size() : exp_wr.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_wr%0d", tag, i), 32'(obs_wr[i]), 32'(exp_wr[i]));
    chk({tag, "_done_cnt"}, 32'(done_cnt), exp_done ? 32'd1 : 32'd0);
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    if (exp_done && done_cnt == 1)
      chk({tag, "_done_lat"}, done_cyc - drop_cyc, PATCH_EN ? 32'd7 : 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] start;
    int          len;
    int          sel;

    reset_n      = 1'b0;
    dl.dl_active = 1'b0;
    dl.dl_valid  = 1'b0;
    dl.dl_data   = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_we",    32'(dl.dma_we),   32'd0);
    chk("rst_addr",  32'(dl.dma_addr), 32'd0);
    chk("rst_din",   32'(dl.dma_din),  32'd0);
    chk("rst_busy",  32'(busy),        32'd0);
    chk("rst_done",  32'(done),        32'd0);
    chk("rst_err",   32'(err),         32'd0);
    chk("rst_ready", 32'(dl.dl_ready), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    tx_q = {8'h01, 8'h04, 8'hA9, 8'h00, 8'h60};
    send_file(100);
    check_file("basic");

    tx_q = {8'hFE, 8'h7F, 8'h11, 8'h22, 8'h33};
    send_file(100);
    check_file("top_of_ram");

    tx_q = {8'h01};
    send_file(100);
    check_file("short_hdr");

    tx_q = {8'h00, 8'h30};
    send_file(100);
    check_file("zero_len");

    tx_q = {8'h00, 8'h90, 8'h55};
    send_file(100);
    check_file("high_start");

    tx_q = {8'h00, 8'h10};
    for (int i = 0; i < 100; i++) tx_q.push_back(8'($urandom));
    send_file(100);
    check_file("burst100");
    if (obs_cyc.size() >= 100)
      chk("burst100_span", obs_cyc[99] - obs_cyc[0], 32'd99);

    for (int f = 0; f < 14; f++) begin
      sel = $urandom_range(9);
      if (sel < 6)      start = 16'($urandom_range(16'h7E00, 16'h0400));
      else if (sel < 9) start = 16'h7FFF - 16'($urandom_range(15));
      else              start = 16'h8000 + 16'($urandom_range(16'h7FFF));
      len = $urandom_range(24);
      tx_q = {start[7:0], start[15:8]};
      repeat (len) tx_q.push_back(8'($urandom));
      send_file($urandom_range(100, 40));
      check_file($sformatf("rand%0d", f));
    end

    // Asynchronous reset in the middle of a DATA burst.
    obs_wr.delete();
    @(negedge clk);
    dl.dl_active = 1'b1;
    dl.dl_valid  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      dl.dl_data = (i == 0) ? 8'h00 : (i == 1) ? 8'h20 : 8'(i);
      @(negedge clk);
    end
    @(posedge clk);
    #2;
    chk("mid_we_before_rst", 32'(dl.dma_we), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("arst_we",    32'(dl.dma_we),   32'd0);
    chk("arst_addr",  32'(dl.dma_addr), 32'd0);
    chk("arst_din",   32'(dl.dma_din),  32'd0);
    chk("arst_busy",  32'(busy),        32'd0);
    chk("arst_done",  32'(done),        32'd0);
    chk("arst_err",   32'(err),         32'd0);
    chk("arst_ready", 32'(dl.dl_ready), 32'd0);
    dl.dl_active = 1'b0;
    dl.dl_valid  = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    obs_wr.delete();
    done_cnt = 0;
    repeat (10) @(negedge clk);
    chk("post_rst_nwr",  32'(obs_wr.size()), 32'd0);
    chk("post_rst_done", 32'(done_cnt),      32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
